// File: rtl/lu_composer_pkg.sv
// Shared constants and the match-entry layout function for the lookup-entry queue composer.
// The entry is built LSB-first so the source-port width can stay a module parameter.
package lu_composer_pkg;

   localparam logic [3:0] ENTRY_DL    = 4'b0001;
   localparam logic [3:0] ENTRY_MPLS  = 4'b0010;
   localparam logic [3:0] ENTRY_ARP   = 4'b0100;
   localparam logic [3:0] ENTRY_IP_TP = 4'b1000;

   localparam int MAC_W         = 48;
   localparam int ETH_W         = 16;
   localparam int VLAN_W        = 16;
   localparam int NW_ADDR_W     = 32;
   localparam int NW_PROTO_W    = 8;
   localparam int NW_TOS_W      = 8;
   localparam int TP_W          = 16;
   localparam int MPLS_LABEL_W  = 20;
   localparam int MPLS_TC_W     = 3;
   localparam int FIXED_LO_W    = 2 * MAC_W + ETH_W + 2 * NW_ADDR_W + NW_PROTO_W + 2 * TP_W;
   localparam int TAG_BLOCK_W   = 8 + VLAN_W + NW_TOS_W;
   localparam int COMPOSE_MAX_W = 512;

   typedef struct packed {
      logic [MAC_W-1:0]        dl_dst;
      logic [MAC_W-1:0]        dl_src;
      logic [ETH_W-1:0]        dl_ethtype;
      logic [VLAN_W-1:0]       dl_vlantag;
      logic [31:0]             src_port;
      logic [MPLS_LABEL_W-1:0] mplslabel;
      logic [MPLS_TC_W-1:0]    mplstc;
      logic [7:0]              arp_op;
      logic [NW_ADDR_W-1:0]    arp_ip_src;
      logic [NW_ADDR_W-1:0]    arp_ip_dst;
      logic [5:0]              ip_tos;
      logic [NW_PROTO_W-1:0]   ip_proto;
      logic [NW_ADDR_W-1:0]    ip_src;
      logic [NW_ADDR_W-1:0]    ip_dst;
      logic [TP_W-1:0]         tp_src;
      logic [TP_W-1:0]         tp_dst;
   } lu_fields_t;

   function automatic logic [COMPOSE_MAX_W-1:0] compose_entry(
      input logic [3:0] etype,
      input bit         mpls_en,
      input int         spt_w,
      input lu_fields_t f
   );
      logic [NW_TOS_W-1:0]     nw_tos;
      logic [NW_ADDR_W-1:0]    nw_src;
      logic [NW_ADDR_W-1:0]    nw_dst;
      logic [NW_PROTO_W-1:0]   nw_proto;
      logic [TP_W-1:0]         t_src;
      logic [TP_W-1:0]         t_dst;
      logic [MPLS_LABEL_W-1:0] label;
      logic [MPLS_TC_W-1:0]    tc;
      logic [31:0]             port_m;
      logic [COMPOSE_MAX_W-1:0] e;
      int                      tag_lo;
      nw_tos   = '0;
      nw_src   = '0;
      nw_dst   = '0;
      nw_proto = '0;
      t_src    = '0;
      t_dst    = '0;
      label    = '0;
      tc       = '0;
      if (etype == ENTRY_MPLS && mpls_en) begin
         label = f.mplslabel;
         tc    = f.mplstc;
      end
      if (etype == ENTRY_ARP) begin
         nw_src   = f.arp_ip_src;
         nw_dst   = f.arp_ip_dst;
         nw_proto = f.arp_op;
      end
      if (etype == ENTRY_IP_TP) begin
         nw_tos   = {f.ip_tos, 2'b00};
         nw_src   = f.ip_src;
         nw_dst   = f.ip_dst;
         nw_proto = f.ip_proto;
         t_src    = f.tp_src;
         t_dst    = f.tp_dst;
      end
      // 1 << 32 wraps to 0 in 32 bits, so a full-width port still masks to all ones
      port_m = f.src_port & ((32'd1 << spt_w) - 32'd1);
      e = '0;
      e[FIXED_LO_W-1:0] = {f.dl_src, f.dl_dst, f.dl_ethtype, nw_src, nw_dst, nw_proto, t_src, t_dst};
      e = e | (COMPOSE_MAX_W'(port_m) << FIXED_LO_W);
      tag_lo = FIXED_LO_W + spt_w;
      e = e | (COMPOSE_MAX_W'(nw_tos) << tag_lo);
      e = e | (COMPOSE_MAX_W'(f.dl_vlantag) << (tag_lo + NW_TOS_W));
      if (mpls_en)
         e = e | (COMPOSE_MAX_W'({tc, label}) << (tag_lo + TAG_BLOCK_W));
      return e;
   endfunction

endpackage

// File: rtl/lu_entry_queue_composer_fifo.sv
// Synchronous request FIFO holding composed entries plus packet length.
// Writes into a full queue and reads from an empty queue are ignored.
module lu_req_fifo #(
   parameter int WIDTH      = 272,
   parameter int LOG2_DEPTH = 2
) (
   input  logic                  asclk,
   input  logic                  aresetn,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [LOG2_DEPTH:0]   level
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG2_DEPTH:0]   level_q, level_d;
   logic                  do_wr, do_rd;

   assign full    = (level_q == (LOG2_DEPTH+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr)
         wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      if (do_rd)
         rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
      if (do_wr && !do_rd)
         level_d = level_q + (LOG2_DEPTH+1)'(1);
      else if (!do_wr && do_rd)
         level_d = level_q - (LOG2_DEPTH+1)'(1);
   end

   always_ff @(posedge asclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; only the pointers and level define validity.
   always_ff @(posedge asclk) begin
      if (do_wr)
         mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/lu_entry_queue_composer.sv
// Composes one flow-table match entry per parsed packet, buffers entries in a small queue
// and presents them to the flow table through a registered req/ack output stage.
module lu_entry_queue_composer
   import lu_composer_pkg::*;
#(
   parameter int OPENFLOW_MATCH_SIZE   = 256,
   parameter int C_AXIS_LEN_DATA_WIDTH = 16,
   parameter int C_AXIS_SPT_DATA_WIDTH = 8,
   parameter int MPLS_ENABLE           = 0,
   parameter int LOG2_DEPTH            = 2,
   parameter int CNT_WIDTH             = 32
) (
   input  logic                             asclk,
   input  logic                             aresetn,
   input  logic                             dl_start,
   input  logic                             dl_done,
   input  logic                             mpls_done,
   input  logic                             arp_done,
   input  logic                             ip_tp_done,
   input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] pkt_len,
   input  logic [C_AXIS_SPT_DATA_WIDTH-1:0] src_port,
   input  logic [47:0]                      dl_dst,
   input  logic [47:0]                      dl_src,
   input  logic [15:0]                      dl_ethtype,
   input  logic [15:0]                      dl_vlantag,
   input  logic [19:0]                      mplslabel,
   input  logic [2:0]                       mplstc,
   input  logic [7:0]                       arp_op,
   input  logic [31:0]                      arp_ip_src,
   input  logic [31:0]                      arp_ip_dst,
   input  logic [5:0]                       ip_tos,
   input  logic [7:0]                       ip_proto,
   input  logic [31:0]                      ip_src,
   input  logic [31:0]                      ip_dst,
   input  logic [15:0]                      tp_src,
   input  logic [15:0]                      tp_dst,
   output logic                             compose_done,
   output logic                             lu_req,
   output logic [OPENFLOW_MATCH_SIZE-1:0]   lu_entry,
   output logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_len,
   input  logic                             lu_ack,
   output logic [LOG2_DEPTH:0]              q_level,
   output logic [CNT_WIDTH-1:0]             drop_count,
   output logic [CNT_WIDTH-1:0]             err_count
);

   localparam int QW = OPENFLOW_MATCH_SIZE + C_AXIS_LEN_DATA_WIDTH;

   logic [3:0]                       done_vec;
   logic                             capture, one_hot;
   logic                             do_write, do_drop, do_err;
   lu_fields_t                       fields;
   logic [OPENFLOW_MATCH_SIZE-1:0]   entry_c;
   logic [QW-1:0]                    fifo_rd_data;
   logic                             fifo_full, fifo_empty, fifo_pop;
   logic                             load;

   logic                             armed_q, armed_d;
   logic                             compose_done_q, compose_done_d;
   logic                             lu_req_q, lu_req_d;
   logic [OPENFLOW_MATCH_SIZE-1:0]   lu_entry_q, lu_entry_d;
   logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_len_q, lu_len_d;
   logic [CNT_WIDTH-1:0]             drop_count_q, drop_count_d;
   logic [CNT_WIDTH-1:0]             err_count_q, err_count_d;

   assign done_vec = {ip_tp_done, arp_done, mpls_done, dl_done};
   assign capture  = armed_q && (done_vec != 4'b0000);
   assign one_hot  = $onehot(done_vec);
   // Fullness is taken from the current level, so a same-cycle pop cannot rescue the entry.
   assign do_write = capture && one_hot && !fifo_full;
   assign do_drop  = capture && one_hot && fifo_full;
   assign do_err   = capture && !one_hot;

   always_comb begin
      fields            = '0;
      fields.dl_dst     = dl_dst;
      fields.dl_src     = dl_src;
      fields.dl_ethtype = dl_ethtype;
      fields.dl_vlantag = dl_vlantag;
      fields.src_port   = 32'(src_port);
      fields.mplslabel  = mplslabel;
      fields.mplstc     = mplstc;
      fields.arp_op     = arp_op;
      fields.arp_ip_src = arp_ip_src;
      fields.arp_ip_dst = arp_ip_dst;
      fields.ip_tos     = ip_tos;
      fields.ip_proto   = ip_proto;
      fields.ip_src     = ip_src;
      fields.ip_dst     = ip_dst;
      fields.tp_src     = tp_src;
      fields.tp_dst     = tp_dst;
   end

   assign entry_c = OPENFLOW_MATCH_SIZE'(compose_entry(done_vec, MPLS_ENABLE != 0,
                                                       C_AXIS_SPT_DATA_WIDTH, fields));

   lu_req_fifo #(
      .WIDTH      (QW),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .asclk   (asclk),
      .aresetn (aresetn),
      .wr_en   (do_write),
      .wr_data ({entry_c, pkt_len}),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (q_level)
   );

   assign load     = !lu_req_q || lu_ack;
   assign fifo_pop = load && !fifo_empty;

   always_comb begin
      armed_d        = armed_q;
      compose_done_d = capture;
      lu_req_d       = lu_req_q;
      lu_entry_d     = lu_entry_q;
      lu_len_d       = lu_len_q;
      drop_count_d   = drop_count_q;
      err_count_d    = err_count_q;
      if (capture)
         armed_d = 1'b0;
      if (dl_start)
         armed_d = 1'b1;
      if (load) begin
         lu_req_d = !fifo_empty;
         if (!fifo_empty)
            {lu_entry_d, lu_len_d} = fifo_rd_data;
      end
      if (do_drop && drop_count_q != '1)
         drop_count_d = drop_count_q + CNT_WIDTH'(1);
      if (do_err && err_count_q != '1)
         err_count_d = err_count_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge asclk) begin
      if (!aresetn) begin
         armed_q        <= 1'b0;
         compose_done_q <= 1'b0;
         lu_req_q       <= 1'b0;
         lu_entry_q     <= '0;
         lu_len_q       <= '0;
         drop_count_q   <= '0;
         err_count_q    <= '0;
      end else begin
         armed_q        <= armed_d;
         compose_done_q <= compose_done_d;
         lu_req_q       <= lu_req_d;
         lu_entry_q     <= lu_entry_d;
         lu_len_q       <= lu_len_d;
         drop_count_q   <= drop_count_d;
         err_count_q    <= err_count_d;
      end
   end

   assign compose_done = compose_done_q;
   assign lu_req       = lu_req_q;
   assign lu_entry     = lu_entry_q;
   assign lu_len       = lu_len_q;
   assign drop_count   = drop_count_q;
   assign err_count    = err_count_q;

endmodule
